// File: rtl/mem_port_arbiter.sv
// Shared memory-port sequencer for the IF and MEM stages: one fixed-latency transaction at a time.
// Optional round-robin tie-breaking is enabled by defining ARB_FAIR_EN.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic          r_owner;      // 0 = fetch, 1 = data
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_ack;
  logic          r_d_ack;

  logic          w_any_req;
  logic          w_grant_d;

  assign w_any_req = if_req | d_req;

`ifdef ARB_FAIR_EN
  logic r_last_d;
  // On a tie the requester that was not served last wins.
  assign w_grant_d = (if_req & d_req) ? ~r_last_d : d_req;
`else
  assign w_grant_d = d_req;
`endif

  // NOTE: every register here is updated with non-blocking assignments so all
  // state advances together at the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= 4'd0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
`ifdef ARB_FAIR_EN
      r_last_d   <= 1'b0;
`endif
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant_d;
            r_we    <= w_grant_d & d_we;
            r_addr  <= w_grant_d ? d_addr : if_addr;
            if (w_grant_d) r_wdata <= d_wdata;
`ifdef ARB_FAIR_EN
            r_last_d <= w_grant_d;
`endif
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= 4'(MEM_LAT);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            // Read data is valid on this edge; a write's return value is dropped.
            if (!r_owner)   r_if_rdata <= mem_rdata;
            else if (!r_we) r_d_rdata  <= mem_rdata;
            r_if_ack <= ~r_owner;
            r_d_ack  <= r_owner;
            r_state  <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = (r_state == S_ISSUE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;

  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-timeline model checked every cycle, directed
// scenarios with literal expectations, and a second instance for the MEM_LAT=1 boundary.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
`ifdef ARB_FAIR_EN
  localparam logic [3:0] EXP_ORDER = 4'b1010;  // D,F,D,F (1 = data)
`else
  localparam logic [3:0] EXP_ORDER = 4'b1111;  // D,D,D,D
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem;

  logic        l1_if_req = 1'b0;
  logic [31:0] l1_if_addr = '0;
  logic [31:0] l1_mem_rdata = 32'hFFFF_FFFF;
  logic        l1_zero1 = 1'b0;
  logic [31:0] l1_zero32 = '0;
  logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_if_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_mem;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ack(l1_if_ack),
    .d_req(l1_zero1), .d_we(l1_zero1), .d_addr(l1_zero32), .d_wdata(l1_zero32),
    .d_rdata(l1_d_rdata), .d_ack(l1_d_ack),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .stall_if(l1_stall_if), .stall_mem(l1_stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  logic [31:0] env_mem   [0:255];
  logic [31:0] model_mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i]   = init_word(i);
      model_mem[i] = init_word(i);
    end
  end

  // Memory environment: writes land on the strobe, reads return data exactly LAT cycles later.
  int          rd_at = -100;
  logic [31:0] rd_val = '0;
  initial forever begin
    @(negedge clk);
    if (rst) rd_at = -100;
    else if (mem_en) begin
      if (mem_we) env_mem[mem_addr[9:2]] = mem_wdata;
      else begin
        rd_at  = cyc + LAT;
        rd_val = env_mem[mem_addr[9:2]];
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    mem_rdata = (cyc == rd_at) ? rd_val : (32'hBAD0_0000 | 32'(cyc & 16'hFFFF));
  end

  // Timeline model: a grant decided in cycle tg issues in tg+1 and acks in tg+2+LAT.
  bit          m_busy = 1'b0, m_own_d = 1'b0, m_we = 1'b0, m_last_d = 1'b0, m_win_d;
  int          m_tg = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
  logic [31:0] e_if_rdata = '0, e_d_rdata = '0, e_addr = '0;
  bit          e_we = 1'b0, x_en, x_resp, x_if_ack, x_d_ack;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_busy = 1'b0; m_last_d = 1'b0;
      e_if_rdata = '0; e_d_rdata = '0; e_addr = '0; e_we = 1'b0;
    end
    x_en   = !rst && m_busy && (cyc == m_tg + 1);
    x_resp = !rst && m_busy && (cyc == m_tg + 2 + LAT);
    if (x_en) begin
      e_addr = m_addr;
      e_we   = m_we;
      if (m_we) model_mem[m_addr[9:2]] = m_wdata;
    end
    if (x_resp && !m_we) begin
      if (m_own_d) e_d_rdata = m_rd;
      else         e_if_rdata = m_rd;
    end
    x_if_ack = x_resp && !m_own_d;
    x_d_ack  = x_resp && m_own_d;

    check("mem_en", mem_en, x_en);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    if (rst)              check("mem_wdata_rst", mem_wdata, 32'h0);
    else if (x_en && m_we) check("mem_wdata", mem_wdata, m_wdata);
    check("if_ack", if_ack, x_if_ack);
    check("d_ack", d_ack, x_d_ack);
    check("if_rdata", if_rdata, e_if_rdata);
    check("d_rdata", d_rdata, e_d_rdata);
    check("stall_if", stall_if, if_req && !x_if_ack);
    check("stall_mem", stall_mem, d_req && !x_d_ack);

    if (!rst) begin
      if (m_busy && cyc == m_tg + 2 + LAT) m_busy = 1'b0;
      else if (!m_busy && (if_req || d_req)) begin
`ifdef ARB_FAIR_EN
        m_win_d  = (if_req && d_req) ? !m_last_d : d_req;
        m_last_d = m_win_d;
`else
        m_win_d  = d_req;
`endif
        m_busy  = 1'b1;
        m_tg    = cyc;
        m_own_d = m_win_d;
        m_we    = m_win_d && d_we;
        m_addr  = m_win_d ? d_addr : if_addr;
        m_wdata = d_wdata;
        m_rd    = model_mem[m_addr[9:2]];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  int          n_acks;
  logic [3:0]  order;
  logic [31:0] prev_d_rdata;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_mem_en", mem_en, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_ack", d_ack, 32'h0);
    tick(); rst = 1'b0;
    repeat (2) tick();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h10;
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("t1_mem_en", mem_en, 32'h1);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_we", mem_we, 32'h0);
      end
      if (n <= 3) check("t1_stall_hi", stall_if, 32'h1);
      if (n == 4) begin
        check("t1_if_ack", if_ack, 32'h1);
        check("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
        check("t1_stall_lo", stall_if, 32'h0);
      end
      tick();
    end
    if_req = 1'b0;
    repeat (2) tick();

    // Simultaneous fetch and data read: data first
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("t2_d_issue", mem_en, 32'h1);
        check("t2_d_addr", mem_addr, 32'h20);
      end
      if (n == 4) check("t2_d_ack", d_ack, 32'h1);
      if (n == 6) begin
        check("t2_f_issue", mem_en, 32'h1);
        check("t2_f_addr", mem_addr, 32'h10);
      end
      if (n <= 8) check("t2_stall_if", stall_if, 32'h1);
      if (n == 9) check("t2_if_ack", if_ack, 32'h1);
      tick();
      if (n == 4) d_req = 1'b0;
    end
    if_req = 1'b0;
    repeat (2) tick();

    // Data write
    prev_d_rdata = 32'hC0DE_0008;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("t3_mem_en", mem_en, 32'h1);
        check("t3_mem_we", mem_we, 32'h1);
        check("t3_mem_addr", mem_addr, 32'h20);
        check("t3_mem_wdata", mem_wdata, 32'h55);
      end
      if (n == 4) begin
        check("t3_d_ack", d_ack, 32'h1);
        check("t3_d_rdata_held", d_rdata, prev_d_rdata);
      end
      check("t3_no_if_ack", if_ack, 32'h0);
      tick();
      if (n == 4) d_req = 1'b0;
    end
    d_we = 1'b0;
    tick();

    // Read back the written word
    d_req = 1'b1; d_addr = 32'h20;
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      if (n == 4) begin
        check("t3b_d_ack", d_ack, 32'h1);
        check("t3b_d_rdata", d_rdata, 32'h55);
      end
      tick();
    end
    d_req = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a fetch, then reissue
    if_req = 1'b1; if_addr = 32'h10;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) check("t5_mem_en", mem_en, 32'h1);
      if (n == 2) begin
        check("t5_rst_mem_en", mem_en, 32'h0);
        check("t5_rst_mem_addr", mem_addr, 32'h0);
        check("t5_rst_if_rdata", if_rdata, 32'h0);
        check("t5_rst_d_rdata", d_rdata, 32'h0);
      end
      if (n == 4) check("t5_no_if_ack", if_ack, 32'h0);
      if (n == 5) begin
        check("t5_reissue", mem_en, 32'h1);
        check("t5_reissue_addr", mem_addr, 32'h10);
      end
      if (n == 8) begin
        check("t5_if_ack", if_ack, 32'h1);
        check("t5_if_rdata", if_rdata, 32'hDEAD_BEEF);
      end
      tick();
      if (n == 1) rst = 1'b1;
      if (n == 3) rst = 1'b0;
    end
    if_req = 1'b0;
    repeat (2) tick();

    // Both requests held continuously for four transactions
    if_req = 1'b1; if_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34;
    n_acks = 0; order = 4'b0;
    for (int n = 0; n < 60 && n_acks < 4; n++) begin
      @(negedge clk);
      if (d_ack || if_ack) begin
        order = {order[2:0], d_ack};
        n_acks++;
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    check("t4_ack_count", 32'(n_acks), 32'h4);
    check("t4_order", {28'h0, order}, {28'h0, EXP_ORDER});
    repeat (3) tick();

    // MEM_LAT=1 boundary on the second instance
    l1_if_req = 1'b1; l1_if_addr = 32'h40;
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      if (n == 0) check("l1_mem_en_c0", l1_mem_en, 32'h0);
      if (n == 1) begin
        check("l1_mem_en_c1", l1_mem_en, 32'h1);
        check("l1_mem_addr", l1_mem_addr, 32'h40);
      end
      if (n == 2) check("l1_no_ack_c2", l1_if_ack, 32'h0);
      if (n == 3) begin
        check("l1_if_ack", l1_if_ack, 32'h1);
        check("l1_if_rdata", l1_if_rdata, 32'h1111_0001);
        check("l1_stall_lo", l1_stall_if, 32'h0);
      end
      tick();
      if (n == 1) l1_mem_rdata = 32'h1111_0001;
      if (n == 2) l1_mem_rdata = 32'hFFFF_FFFF;
    end
    l1_if_req = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for a single shared memory port used by both the fetch (IF) stage and the data (MEM) stage of the 5-stage pipeline. It accepts level-held requests from both stages and issues one transaction at a time to a fixed-latency memory. It returns read data with a one-cycle acknowledge and produces per-stage stall signals, which the hazard logic ORs into the IF/ID and EX/MEM stall terms.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  fetch request; held high with if_addr stable until if_ack
- if_addr  input  AW  fetch address
- if_rdata  output  DW  fetch data; valid while if_ack=1
- if_ack  output  1  one-cycle completion pulse for the fetch transaction
- d_req  input  1  data request; held high, with d_we/d_addr/d_wdata stable, until d_ack
- d_we  input  1  1 = write, 0 = read
- d_addr  input  AW  data address
- d_wdata  input  DW  write data
- d_rdata  output  DW  read data; valid while d_ack=1 and the transaction was a read
- d_ack  output  1  one-cycle completion pulse for the data transaction
- mem_en  output  1  one-cycle issue strobe to memory
- mem_we  output  1  write enable; qualified by mem_en
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle
- stall_if  output  1  equals if_req & ~if_ack
- stall_mem  output  1  equals d_req & ~d_ack

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. A latched owner bit records the granted requester: 0 = fetch, 1 = data.
- IDLE: if either request is high, arbitrate, latch the owner, latch address/we/wdata from the winner, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): mem_en=1; mem_we = latched we (always 0 for fetch); mem_addr/mem_wdata driven from the latch. Load the latency counter with MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter equals 1, capture mem_rdata at the clock edge into the owner's rdata register and go to RESP.
- RESP (1 cycle): assert the owner's ack. The next state is always IDLE. Requests seen during RESP are ignored, because the just-served requester may still be holding req high.
- Arbitration (default): fixed priority, data over fetch.
- Writes use the same sequence and timing. A write's mem_rdata capture is discarded, so d_rdata holds its previous value.
- if_rdata and d_rdata hold their value between acks.
- mem_addr, mem_wdata and mem_we hold their last value outside ISSUE. Only mem_en qualifies them.
- Dropping a request before its ack is a protocol violation, and the resulting behaviour is not defined.
- The latency counter width is 4 bits.

## Timing
- Reset: state=IDLE. Outputs mem_en, mem_we, if_ack and d_ack are 0; mem_addr, mem_wdata, if_rdata and d_rdata are 0. The owner bit, latch and counter are cleared to 0.
- Reset mid-transaction returns the FSM to IDLE immediately and no ack is produced. A write already strobed by mem_en still completes in memory. Read data still arriving from memory is ignored.
- Request high in cycle t while in IDLE gives mem_en in t+1, mem_rdata sampled at the end of t+1+MEM_LAT, and ack in t+2+MEM_LAT.
- Request-to-ack latency is MEM_LAT+2 cycles. Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Stalls are combinational from the inputs and the registered acks. The stall drops in the ack cycle.

## Configuration
- ARB_FAIR_EN defined: round-robin arbitration when both requests are pending in IDLE. The requester not served last wins. A last-served bit is reset to fetch, so data wins the first tie.
- ARB_FAIR_EN undefined: fixed data-over-fetch priority, and the last-served bit is not instantiated.

## Test plan
- Fetch only, MEM_LAT=2, if_req in cycle 0 with if_addr=0x10, memory returns 0xDEADBEEF: mem_en=1 with mem_addr=0x10 and mem_we=0 in cycle 1; if_ack=1 with if_rdata=0xDEADBEEF in cycle 4; stall_if high in cycles 0-3 and low in cycle 4.
- if_req and d_req (read of 0x20) both rise in cycle 0: data is issued in cycle 1 and d_ack occurs in cycle 4; fetch mem_en occurs in cycle 6 and if_ack in cycle 9; stall_if stays high through cycle 8.
- Data write with d_addr=0x20 and d_wdata=0x55 in cycle 0: cycle 1 shows mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x55; d_ack in cycle 4; d_rdata unchanged; if_ack never asserts.
- Both requests held continuously for 4 transactions: without ARB_FAIR_EN the grant order is D,D,D,D and the fetch is starved; with ARB_FAIR_EN the order is D,F,D,F.
- rst pulsed in cycle 2 of a fetch started in cycle 0: all outputs are 0 immediately and there is no if_ack in cycle 4. With if_req still high after reset release, the transaction is reissued with mem_en one cycle after the first IDLE cycle.
- MEM_LAT=1 boundary: fetch in cycle 0 gives mem_en in cycle 1, data captured at the end of cycle 2, and if_ack in cycle 3.
